// File: rtl/nn_pkg.sv
// Shared constants for the network result path: word sizes, unit count and
// the argmax stage state encoding.
package nn_pkg;

    localparam int DATA_W  = 32;
    localparam int N_UNITS = 4;
    localparam int IDX_W   = 2;
    localparam int CNT_W   = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    // Signed strict greater-than over the full word width.
    function automatic logic signed_gt(input logic [DATA_W-1:0] a,
                                       input logic [DATA_W-1:0] b);
        return $signed(a) > $signed(b);
    endfunction

endpackage

// File: rtl/result_argmax_stage_rise_detect.sv
// Rising-edge detector for a level input. The history flop resets to 1 so a
// level already high when reset is released does not look like an edge.
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic rise
);

    logic prev_q;
    logic prev_d;

    always_comb begin
        prev_d = level;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign rise = level & ~prev_q;

endmodule

// File: rtl/result_argmax_stage.sv
// Snapshots four unit outputs on each rising edge of layer_done, scans them
// one per cycle for the signed maximum and offers the result via valid/ready.
module result_argmax_stage
    import nn_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              layer_done,
    input  logic [DATA_W-1:0] unit_out0,
    input  logic [DATA_W-1:0] unit_out1,
    input  logic [DATA_W-1:0] unit_out2,
    input  logic [DATA_W-1:0] unit_out3,
    input  logic              res_ready,
    output logic              res_valid,
    output logic [IDX_W-1:0]  res_class,
    output logic [DATA_W-1:0] res_value,
    output logic              res_tie,
    output logic              busy,
    output logic [CNT_W-1:0]  drop_count
);

    localparam logic [IDX_W:0] LAST_IDX = (IDX_W+1)'(N_UNITS - 1);

    // Handshake: a result transfers on any rising clk edge where res_valid
    // and res_ready are both high; res_class/value/tie hold while res_valid.
    logic              done_rise;

    logic [1:0]        state_q,     state_d;
    logic [DATA_W-1:0] snap_q [N_UNITS];
    logic [DATA_W-1:0] snap_d [N_UNITS];
    logic [IDX_W-1:0]  best_idx_q,  best_idx_d;
    logic [DATA_W-1:0] best_val_q,  best_val_d;
    logic              tie_q,       tie_d;
    logic [IDX_W:0]    scan_idx_q,  scan_idx_d;
    logic              res_valid_q, res_valid_d;
    logic [IDX_W-1:0]  res_class_q, res_class_d;
    logic [DATA_W-1:0] res_value_q, res_value_d;
    logic              res_tie_q,   res_tie_d;
    logic [CNT_W-1:0]  drop_q,      drop_d;

    logic [DATA_W-1:0] cand;

    rise_detect u_rise_detect (
        .clk   (clk),
        .reset (reset),
        .level (layer_done),
        .rise  (done_rise)
    );

    always_comb begin
        state_d     = state_q;
        snap_d      = snap_q;
        best_idx_d  = best_idx_q;
        best_val_d  = best_val_q;
        tie_d       = tie_q;
        scan_idx_d  = scan_idx_q;
        res_valid_d = res_valid_q;
        res_class_d = res_class_q;
        res_value_d = res_value_q;
        res_tie_d   = res_tie_q;
        drop_d      = drop_q;
        cand        = snap_q[scan_idx_q[IDX_W-1:0]];

        case (state_q)
            ST_IDLE: begin
                if (done_rise) begin
                    snap_d[0]  = unit_out0;
                    snap_d[1]  = unit_out1;
                    snap_d[2]  = unit_out2;
                    snap_d[3]  = unit_out3;
                    best_idx_d = '0;
                    best_val_d = unit_out0;
                    tie_d      = 1'b0;
                    scan_idx_d = (IDX_W+1)'(1);
                    state_d    = ST_SCAN;
                end
            end
            ST_SCAN: begin
                // Strict compare keeps the lowest index on equal values.
                if (signed_gt(cand, best_val_q)) begin
                    best_idx_d = scan_idx_q[IDX_W-1:0];
                    best_val_d = cand;
                    tie_d      = 1'b0;
                end else if (cand == best_val_q) begin
                    tie_d = 1'b1;
                end
                if (scan_idx_q == LAST_IDX) begin
                    res_class_d = best_idx_d;
                    res_value_d = best_val_d;
                    res_tie_d   = tie_d;
                    res_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                end else begin
                    scan_idx_d = scan_idx_q + (IDX_W+1)'(1);
                end
            end
            ST_HOLD: begin
                if (res_valid_q && res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                res_valid_d = 1'b0;
            end
        endcase

        // Any edge outside IDLE is lost, including one during the handshake.
        if (done_rise && (state_q != ST_IDLE) && (drop_q != {CNT_W{1'b1}})) begin
            drop_d = drop_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            for (int i = 0; i < N_UNITS; i++) begin
                snap_q[i] <= '0;
            end
            best_idx_q  <= '0;
            best_val_q  <= '0;
            tie_q       <= 1'b0;
            scan_idx_q  <= '0;
            res_valid_q <= 1'b0;
            res_class_q <= '0;
            res_value_q <= '0;
            res_tie_q   <= 1'b0;
            drop_q      <= '0;
        end else begin
            state_q     <= state_d;
            snap_q      <= snap_d;
            best_idx_q  <= best_idx_d;
            best_val_q  <= best_val_d;
            tie_q       <= tie_d;
            scan_idx_q  <= scan_idx_d;
            res_valid_q <= res_valid_d;
            res_class_q <= res_class_d;
            res_value_q <= res_value_d;
            res_tie_q   <= res_tie_d;
            drop_q      <= drop_d;
        end
    end

    assign res_valid  = res_valid_q;
    assign res_class  = res_class_q;
    assign res_value  = res_value_q;
    assign res_tie    = res_tie_q;
    assign busy       = (state_q != ST_IDLE);
    assign drop_count = drop_q;

endmodule

// File: tb/tb_result_argmax_stage.sv
// Directed bench for result_argmax_stage: argmax, ties, latency, backpressure,
// dropped edges, reset behaviour, snapshot isolation and counter saturation.
module tb_result_argmax_stage;

    logic        clk;
    logic        reset;
    logic        layer_done;
    logic [31:0] unit_out0, unit_out1, unit_out2, unit_out3;
    logic        res_ready;
    logic        res_valid;
    logic [1:0]  res_class;
    logic [31:0] res_value;
    logic        res_tie;
    logic        busy;
    logic [7:0]  drop_count;

    int checks   = 0;
    int failures = 0;

    // Expected results: {tie, class, value}
    logic [34:0] exp_q [$];

    result_argmax_stage dut (
        .clk        (clk),
        .reset      (reset),
        .layer_done (layer_done),
        .unit_out0  (unit_out0),
        .unit_out1  (unit_out1),
        .unit_out2  (unit_out2),
        .unit_out3  (unit_out3),
        .res_ready  (res_ready),
        .res_valid  (res_valid),
        .res_class  (res_class),
        .res_value  (res_value),
        .res_tie    (res_tie),
        .busy       (busy),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_outs(input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] c, input logic [31:0] d);
        unit_out0 = a;
        unit_out1 = b;
        unit_out2 = c;
        unit_out3 = d;
    endtask

    // Drive outputs, record the expected result and raise done for one cycle.
    task automatic launch(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c, input logic [31:0] d,
                          input logic [1:0] ecls, input logic [31:0] eval,
                          input logic etie);
        set_outs(a, b, c, d);
        exp_q.push_back({etie, ecls, eval});
        layer_done = 1'b1;
        tick();
        layer_done = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!res_valid && n < 12) begin
            tick();
            n++;
        end
        check(tag, res_valid, 1);
    endtask

    task automatic check_result(input string tag);
        logic [34:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_no_expected"}, 1, 0);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_class"}, res_class, e[33:32]);
            check({tag, "_value"}, res_value, e[31:0]);
            check({tag, "_tie"}, res_tie, e[34]);
        end
    endtask

    initial begin
        reset      = 1'b1;
        layer_done = 1'b0;
        res_ready  = 1'b1;
        set_outs('0, '0, '0, '0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        check("rst_valid", res_valid, 0);
        check("rst_busy",  busy, 0);
        check("rst_drop",  drop_count, 0);
        check("rst_class", res_class, 0);
        check("rst_value", res_value, 0);
        check("rst_tie",   res_tie, 0);

        // Basic argmax with exact latency: capture edge then three compare edges.
        launch(32'd5, 32'hFFFF_FFFD, 32'd9, 32'd2, 2'd2, 32'd9, 1'b0);
        check("lat_busy_after_capture", busy, 1);
        check("lat_valid_after_capture", res_valid, 0);
        tick();
        tick();
        check("lat_valid_before_last", res_valid, 0);
        tick();
        check("lat_valid_on_time", res_valid, 1);
        check_result("basic");
        tick();
        check("basic_valid_cleared", res_valid, 0);
        check("basic_idle", busy, 0);
        check("basic_class_kept", res_class, 2);

        // Tie among negatives: lowest index wins.
        launch(32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFEC,
               2'd1, 32'hFFFF_FFFF, 1'b1);
        wait_valid("neg_tie_valid");
        check_result("neg_tie");
        tick();

        // Most negative value in slot 0, zeros elsewhere.
        launch(32'h8000_0000, 32'd0, 32'd0, 32'd0, 2'd1, 32'd0, 1'b1);
        wait_valid("minint_valid");
        check_result("minint");
        tick();

        // Snapshot isolation: inputs change right after capture.
        launch(32'd1, 32'd2, 32'd3, 32'd4, 2'd3, 32'd4, 1'b0);
        set_outs(32'd100, 32'd200, 32'd300, 32'd50);
        wait_valid("snap_valid");
        check_result("snap");
        tick();

        // Backpressure with dropped edges.
        res_ready = 1'b0;
        launch(32'd10, 32'd20, 32'd30, 32'd5, 2'd2, 32'd30, 1'b0);
        wait_valid("bp_valid");
        set_outs(32'd999, 32'd999, 32'd999, 32'd999);
        for (int i = 0; i < 2; i++) begin
            layer_done = 1'b1;
            tick();
            layer_done = 1'b0;
            tick();
        end
        check("bp_valid_held", res_valid, 1);
        check("bp_drop", drop_count, 2);
        check_result("bp_held");
        res_ready = 1'b1;
        tick();
        check("bp_valid_cleared", res_valid, 0);
        check("bp_busy_cleared", busy, 0);

        // Edge coinciding with the handshake is dropped.
        res_ready = 1'b0;
        launch(32'd7, 32'd7, 32'd1, 32'd1, 2'd0, 32'd7, 1'b1);
        wait_valid("hs_valid");
        check_result("hs");
        res_ready  = 1'b1;
        layer_done = 1'b1;
        tick();
        layer_done = 1'b0;
        check("hs_valid_cleared", res_valid, 0);
        check("hs_busy", busy, 0);
        check("hs_drop", drop_count, 3);
        tick();

        // Done level high across reset release is not an edge.
        layer_done = 1'b1;
        reset      = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        check("lvl_busy", busy, 0);
        tick();
        check("lvl_busy_later", busy, 0);
        check("lvl_drop", drop_count, 0);
        layer_done = 1'b0;
        tick();
        launch(32'd3, 32'd8, 32'd8, 32'hFFFF_FF00, 2'd1, 32'd8, 1'b1);
        check("lvl_capture_busy", busy, 1);
        wait_valid("lvl_valid");
        check_result("lvl");
        tick();

        // Edge during SCAN is dropped, then reset aborts the scan.
        set_outs(32'd4, 32'd3, 32'd2, 32'd1);
        layer_done = 1'b1;
        tick();
        layer_done = 1'b0;
        tick();
        layer_done = 1'b1;
        tick();
        layer_done = 1'b0;
        check("scan_drop", drop_count, 1);
        check("scan_busy", busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_valid", res_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_drop", drop_count, 0);
        tick();
        check("abort_stays_idle", busy, 0);

        // Saturation of the drop counter.
        res_ready = 1'b0;
        launch(32'd1, 32'd1, 32'd1, 32'd2, 2'd3, 32'd2, 1'b0);
        wait_valid("sat_valid");
        check_result("sat");
        for (int i = 0; i < 300; i++) begin
            layer_done = 1'b1;
            tick();
            layer_done = 1'b0;
            tick();
        end
        check("sat_drop", drop_count, 255);
        check("sat_valid_held", res_valid, 1);
        res_ready = 1'b1;
        tick();
        check("sat_valid_cleared", res_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
